num_tokenizer: RTL and testbench
================================

Name: num_tokenizer

Overview:
- Inverse of the number-builder stage: expands a packed 44-bit entry array (numbers and operator tokens) back into the 8-bit token stream used by the keypad/display path.
- Used to render evaluator results, or a rebuilt expression, as display tokens.
- Started by an eval rising edge, processes entries sequentially, and pulses done when finished.

Parameters:
- depth, 10, number of entries in the input array.
- outDepth, 32, number of entries in the output token array.
- width, 8, token width.
- newWidth, 44, packed entry width.
- MINUS_TOK, 8'hAD, token emitted for a negative sign.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- eval  in  1  start request; a run starts on its rising edge.
- size  in  $clog2(depth+1)  number of valid input entries.
- memIn  in  [newWidth-1:0] x depth  packed entries. Fields: [43:42] tag, [41] sign, [40:7] mantissa, [6:0] signed exponent.
- newSize  out  $clog2(outDepth+1)  number of tokens written.
- memOut  out  [width-1:0] x outDepth  output tokens.
- overflow  out  1  sticky for the run; a token was dropped because outDepth was exceeded.
- badTag  out  1  sticky for the run; an entry had tag 2'b10 or 2'b11.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (reset low, asynchronous): memOut all zero, newSize=0, overflow=0, badTag=0, done=0, state=IDLE. The eval edge register clears to 0.
- Start: doEval = eval & ~evalPrev.
  - In any state, doEval clears newSize, overflow, badTag and the entry index i, then enters FETCH.
  - A run in progress is abandoned when this happens.
- FETCH:
  - If i >= size or i >= depth, go to FINISH.
  - Tag 01: emit memIn[i][7:0], i++, stay in FETCH (1 cycle/token).
  - Tag 1x: set badTag, i++, emit nothing.
  - Tag 00: latch sign, mantissa and exp; clear the digit count n; go to DIV.
- DIV:
  - Each cycle push mantissa%10 onto a 12-entry digit stack, set mantissa=mantissa/10, n++.
  - Leave DIV when the quotient is 0 after the push, so mantissa 0 yields the single digit 0.
  - Maximum 11 cycles for a 34-bit mantissa.
- EMIT, one token per cycle, in this order:
  - MINUS_TOK, if sign=1.
  - If exp<0 and n <= -exp: token 0x00, dot 0xDD, then (-exp - n) tokens 0x00.
  - Digits popped most-significant first.
  - If exp<0 and n > -exp: dot 0xDD inserted after (n + exp) digits.
  - If exp>0: exp tokens 0x00 appended after the digits.
  - Then i++ and return to FETCH.
- Emit rule:
  - If newSize < outDepth: write memOut[newSize] and increment newSize.
  - Otherwise drop the token, set overflow, and hold newSize at outDepth.
  - Processing continues to the end of input either way.
- FINISH: go to IDLE and assert done for exactly one cycle.
- Latency: done is high the cycle after the last token write.
- memOut entries at or above newSize are not cleared between runs.
- Reset mid-run aborts immediately to IDLE with no done pulse.
- size > depth is clamped to depth.

Optional Feature:
- Macro: NUM_TOKENIZER_CONST_EN.
- When defined, in FETCH a tag-00 entry whose {sign, mantissa, exp} equals {0, 2718281828, -9} emits the single token 0xC0. An entry equal to {0, 3141592653, -9} emits the single token 0xC1. Both take 1 cycle and bypass DIV/EMIT.
- When undefined, these entries are expanded as ordinary digits, e.g. 2.718281828.

Test Plan:
- Entries {num 0,12345,-2}, {op 0x2A}, {num 0,7,0}; pulse eval -> tokens 01 02 03 DD 04 05 2A 07, newSize=8, done pulses once.
- Entry {num 1,5,-3} -> AD 00 DD 00 00 05, newSize=6.
- Entries {num 0,0,0}, {num 0,3,+2} -> 00 03 00 00, newSize=4.
- Mantissa 2^34-1, exp 0, repeated 3 times -> 33 tokens needed: newSize=32, overflow=1, done still pulses.
- Entry tag 2'b10 between two op entries -> only the two op tokens emitted, badTag=1. Second eval edge mid-run -> newSize restarts from 0.
- Entry {num 0,3141592653,-9} -> C1 with NUM_TOKENIZER_CONST_EN defined, 03 DD 01 04 01 05 09 02 06 05 03 without it. Assert reset low mid-DIV -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/num_tokenizer.sv
// Expands packed number/operator entries back into 8-bit display tokens.
// Optional NUM_TOKENIZER_CONST_EN maps the e and pi constants to single tokens 0xC0/0xC1.
module num_tokenizer #(
    parameter int unsigned depth     = 10,
    parameter int unsigned outDepth  = 32,
    parameter int unsigned width     = 8,
    parameter int unsigned newWidth  = 44,
    parameter logic [7:0]  MINUS_TOK = 8'hAD
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 eval,
    input  logic [$clog2(depth+1)-1:0]           size,
    input  logic [depth-1:0][newWidth-1:0]       memIn,
    output logic [$clog2(outDepth+1)-1:0]        newSize,
    output logic [outDepth-1:0][width-1:0]       memOut,
    output logic                                 overflow,
    output logic                                 badTag,
    output logic                                 done
);
    localparam int unsigned SW  = $clog2(depth + 1);
    localparam int unsigned OW  = $clog2(outDepth + 1);
    localparam int unsigned OIW = $clog2(outDepth);
    localparam int unsigned MW  = 34;
    localparam int unsigned NW  = 4;
    localparam int unsigned CW  = 8;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DIV, S_SIGN, S_LEAD, S_DIG, S_DOT, S_TRAIL, S_FINISH
    } state_t;

    state_t                          state_q, state_d;
    logic                            eval_prev_q, eval_prev_d;
    logic [SW-1:0]                   i_q, i_d;
    logic                            sign_q, sign_d;
    logic [MW-1:0]                   mant_q, mant_d;
    logic [6:0]                      exp_q, exp_d;
    logic [NW-1:0]                   n_q, n_d;
    logic [NW-1:0]                   sp_q, sp_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [11:0][3:0]                stack_q, stack_d;
    logic [OW-1:0]                   new_size_q, new_size_d;
    logic [outDepth-1:0][width-1:0]  mem_out_q, mem_out_d;
    logic                            overflow_q, overflow_d;
    logic                            bad_tag_q, bad_tag_d;
    logic                            done_q, done_d;

    logic                            do_eval;
    logic [newWidth-1:0]             entry;
    logic signed [8:0]               int_part;
    logic [8:0]                      lead_cnt;
    logic                            lead_mode;
    logic                            dot_mode;
    logic [NW-1:0]                   popped_new;
    logic                            emit_v;
    logic [width-1:0]                emit_tok;

    assign newSize  = new_size_q;
    assign memOut   = mem_out_q;
    assign overflow = overflow_q;
    assign badTag   = bad_tag_q;
    assign done     = done_q;

    // Digits left of the decimal point; non-positive means a "0." prefix is needed.
    always_comb begin
        do_eval    = eval & ~eval_prev_q;
        entry      = memIn[i_q];
        int_part   = {5'b0, n_q} + {{2{exp_q[6]}}, exp_q};
        lead_cnt   = -int_part;
        lead_mode  = exp_q[6] && (int_part <= 9'sd0);
        dot_mode   = exp_q[6] && (int_part > 9'sd0);
        popped_new = n_q - sp_q + NW'(1);
    end

    always_comb begin
        state_d     = state_q;
        eval_prev_d = eval;
        i_d         = i_q;
        sign_d      = sign_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        n_d         = n_q;
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        stack_d     = stack_q;
        new_size_d  = new_size_q;
        mem_out_d   = mem_out_q;
        overflow_d  = overflow_q;
        bad_tag_d   = bad_tag_q;
        done_d      = 1'b0;
        emit_v      = 1'b0;
        emit_tok    = '0;

        if (do_eval) begin
            new_size_d = '0;
            overflow_d = 1'b0;
            bad_tag_d  = 1'b0;
            i_d        = '0;
            state_d    = S_FETCH;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_FETCH: begin
                    if (i_q >= size || i_q >= SW'(depth)) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else if (entry[43:42] == 2'b01) begin
                        emit_v   = 1'b1;
                        emit_tok = entry[width-1:0];
                        i_d      = i_q + SW'(1);
                    end else if (entry[43]) begin
                        bad_tag_d = 1'b1;
                        i_d       = i_q + SW'(1);
`ifdef NUM_TOKENIZER_CONST_EN
                    end else if (entry[41:0] == {1'b0, 34'd2718281828, 7'h77}) begin
                        emit_v   = 1'b1;
                        emit_tok = width'(8'hC0);
                        i_d      = i_q + SW'(1);
                    end else if (entry[41:0] == {1'b0, 34'd3141592653, 7'h77}) begin
                        emit_v   = 1'b1;
                        emit_tok = width'(8'hC1);
                        i_d      = i_q + SW'(1);
`endif
                    end else begin
                        sign_d  = entry[41];
                        mant_d  = entry[40:7];
                        exp_d   = entry[6:0];
                        n_d     = '0;
                        state_d = S_DIV;
                    end
                end
                S_DIV: begin
                    stack_d[n_q] = 4'(mant_q % 34'd10);
                    mant_d       = mant_q / 34'd10;
                    n_d          = n_q + NW'(1);
                    if (mant_q < 34'd10) begin
                        sp_d    = n_q + NW'(1);
                        state_d = S_SIGN;
                    end
                end
                S_SIGN: begin
                    emit_v   = sign_q;
                    emit_tok = width'(MINUS_TOK);
                    cnt_d    = '0;
                    state_d  = lead_mode ? S_LEAD : S_DIG;
                end
                // "0", ".", then the zeros between the point and the first digit.
                S_LEAD: begin
                    emit_v   = 1'b1;
                    emit_tok = (cnt_q == CW'(1)) ? width'(8'hDD) : '0;
                    cnt_d    = cnt_q + CW'(1);
                    if ({1'b0, cnt_q} == lead_cnt + 9'd1) state_d = S_DIG;
                end
                S_DIG: begin
                    emit_v   = 1'b1;
                    emit_tok = width'(stack_q[sp_q - NW'(1)]);
                    sp_d     = sp_q - NW'(1);
                    if (sp_q == NW'(1)) begin
                        if (!exp_q[6] && exp_q != 7'd0) begin
                            cnt_d   = '0;
                            state_d = S_TRAIL;
                        end else begin
                            i_d     = i_q + SW'(1);
                            state_d = S_FETCH;
                        end
                    end else if (dot_mode && popped_new == int_part[NW-1:0]) begin
                        state_d = S_DOT;
                    end
                end
                S_DOT: begin
                    emit_v   = 1'b1;
                    emit_tok = width'(8'hDD);
                    state_d  = S_DIG;
                end
                S_TRAIL: begin
                    emit_v   = 1'b1;
                    emit_tok = '0;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(exp_q) - CW'(1)) begin
                        i_d     = i_q + SW'(1);
                        state_d = S_FETCH;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase

            // Full output array drops the token but keeps the run going.
            if (emit_v) begin
                if (new_size_q < OW'(outDepth)) begin
                    mem_out_d[new_size_q[OIW-1:0]] = emit_tok;
                    new_size_d = new_size_q + OW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            eval_prev_q <= 1'b0;
            i_q         <= '0;
            sign_q      <= 1'b0;
            mant_q      <= '0;
            exp_q       <= '0;
            n_q         <= '0;
            sp_q        <= '0;
            cnt_q       <= '0;
            stack_q     <= '0;
            new_size_q  <= '0;
            mem_out_q   <= '0;
            overflow_q  <= 1'b0;
            bad_tag_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            eval_prev_q <= eval_prev_d;
            i_q         <= i_d;
            sign_q      <= sign_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            n_q         <= n_d;
            sp_q        <= sp_d;
            cnt_q       <= cnt_d;
            stack_q     <= stack_d;
            new_size_q  <= new_size_d;
            mem_out_q   <= mem_out_d;
            overflow_q  <= overflow_d;
            bad_tag_q   <= bad_tag_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_num_tokenizer.sv
// Directed bench for num_tokenizer: each task drives one scenario and checks tokens/flags.
module tb_num_tokenizer;
    logic             clock;
    logic             reset;
    logic             eval;
    logic [3:0]       size;
    logic [9:0][43:0] mem_in;
    logic [5:0]       new_size;
    logic [31:0][7:0] mem_out;
    logic             overflow;
    logic             bad_tag;
    logic             done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] exp_tok[$];

    num_tokenizer dut (
        .clock    (clock),
        .reset    (reset),
        .eval     (eval),
        .size     (size),
        .memIn    (mem_in),
        .newSize  (new_size),
        .memOut   (mem_out),
        .overflow (overflow),
        .badTag   (bad_tag),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (done) done_cnt++;

    function automatic logic [43:0] num(input logic s, input logic [33:0] m, input logic [6:0] e);
        return {2'b00, s, m, e};
    endfunction

    function automatic logic [43:0] op(input logic [7:0] t);
        return {2'b01, 34'd0, t};
    endfunction

    // Pulse eval, then wait (bounded) for done plus a few settle cycles.
    task automatic run_eval(output bit got_done);
        got_done = 1'b0;
        done_cnt = 0;
        @(negedge clock) eval = 1'b1;
        @(negedge clock) eval = 1'b0;
        for (int k = 0; k < 600 && done_cnt == 0; k++) @(negedge clock);
        got_done = (done_cnt != 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0; eval = 1'b0; size = '0; mem_in = '0;
        repeat (2) @(negedge clock);
        checks++; if (new_size !== 6'd0) begin failures++; $display("FAIL reset_newsize got=%0d exp=0", new_size); end
        checks++; if (mem_out !== '0) begin failures++; $display("FAIL reset_memout got=%0h exp=0", mem_out); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (bad_tag !== 1'b0) begin failures++; $display("FAIL reset_badtag got=%b exp=0", bad_tag); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic;
        bit ok;
        mem_in = '0;
        mem_in[0] = num(1'b0, 34'd12345, -7'sd2);
        mem_in[1] = op(8'h2A);
        mem_in[2] = num(1'b0, 34'd7, 7'd0);
        size = 4'd3;
        exp_tok = '{8'h01, 8'h02, 8'h03, 8'hDD, 8'h04, 8'h05, 8'h2A, 8'h07};
        run_eval(ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (new_size !== 6'd8) begin failures++; $display("FAIL basic_newsize got=%0d exp=8", new_size); end
        foreach (exp_tok[k]) begin
            checks++;
            if (mem_out[k] !== exp_tok[k]) begin failures++; $display("FAIL basic_tok%0d got=%0h exp=%0h", k, mem_out[k], exp_tok[k]); end
        end
        checks++; if (overflow !== 1'b0 || bad_tag !== 1'b0) begin failures++; $display("FAIL basic_flags got=%b%b exp=00", overflow, bad_tag); end
    endtask

    task automatic test_negative;
        bit ok;
        mem_in = '0;
        mem_in[0] = num(1'b1, 34'd5, -7'sd3);
        size = 4'd1;
        exp_tok = '{8'hAD, 8'h00, 8'hDD, 8'h00, 8'h00, 8'h05};
        run_eval(ok);
        checks++; if (!ok) begin failures++; $display("FAIL neg_timeout got=no_done exp=done"); end
        checks++; if (new_size !== 6'd6) begin failures++; $display("FAIL neg_newsize got=%0d exp=6", new_size); end
        foreach (exp_tok[k]) begin
            checks++;
            if (mem_out[k] !== exp_tok[k]) begin failures++; $display("FAIL neg_tok%0d got=%0h exp=%0h", k, mem_out[k], exp_tok[k]); end
        end
    endtask

    task automatic test_zero_exp;
        bit ok;
        mem_in = '0;
        mem_in[0] = num(1'b0, 34'd0, 7'd0);
        mem_in[1] = num(1'b0, 34'd3, 7'd2);
        size = 4'd2;
        exp_tok = '{8'h00, 8'h03, 8'h00, 8'h00};
        run_eval(ok);
        checks++; if (!ok) begin failures++; $display("FAIL zexp_timeout got=no_done exp=done"); end
        checks++; if (new_size !== 6'd4) begin failures++; $display("FAIL zexp_newsize got=%0d exp=4", new_size); end
        foreach (exp_tok[k]) begin
            checks++;
            if (mem_out[k] !== exp_tok[k]) begin failures++; $display("FAIL zexp_tok%0d got=%0h exp=%0h", k, mem_out[k], exp_tok[k]); end
        end
    endtask

    task automatic test_overflow;
        bit ok;
        mem_in = '0;
        for (int k = 0; k < 3; k++) mem_in[k] = num(1'b0, 34'h3_FFFF_FFFF, 7'd0);
        size = 4'd3;
        run_eval(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got=no_done exp=done"); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL ovf_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (new_size !== 6'd32) begin failures++; $display("FAIL ovf_newsize got=%0d exp=32", new_size); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (mem_out[0] !== 8'h01) begin failures++; $display("FAIL ovf_tok0 got=%0h exp=01", mem_out[0]); end
        checks++; if (mem_out[10] !== 8'h03) begin failures++; $display("FAIL ovf_tok10 got=%0h exp=03", mem_out[10]); end
        checks++; if (mem_out[31] !== 8'h08) begin failures++; $display("FAIL ovf_tok31 got=%0h exp=08", mem_out[31]); end
    endtask

    task automatic test_bad_tag;
        bit ok;
        mem_in = '0;
        mem_in[0] = op(8'h11);
        mem_in[1] = {2'b10, 42'h155};
        mem_in[2] = op(8'h22);
        size = 4'd3;
        run_eval(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bad_timeout got=no_done exp=done"); end
        checks++; if (new_size !== 6'd2) begin failures++; $display("FAIL bad_newsize got=%0d exp=2", new_size); end
        checks++; if (mem_out[0] !== 8'h11 || mem_out[1] !== 8'h22) begin failures++; $display("FAIL bad_toks got=%0h,%0h exp=11,22", mem_out[0], mem_out[1]); end
        checks++; if (bad_tag !== 1'b1) begin failures++; $display("FAIL bad_flag got=%b exp=1", bad_tag); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bad_ovf_cleared got=%b exp=0", overflow); end
    endtask

    task automatic test_size_clamp;
        bit ok;
        for (int k = 0; k < 10; k++) mem_in[k] = op(8'(8'h30 + k));
        size = 4'd15;
        run_eval(ok);
        checks++; if (!ok) begin failures++; $display("FAIL clamp_timeout got=no_done exp=done"); end
        checks++; if (new_size !== 6'd10) begin failures++; $display("FAIL clamp_newsize got=%0d exp=10", new_size); end
        checks++; if (mem_out[9] !== 8'h39) begin failures++; $display("FAIL clamp_tok9 got=%0h exp=39", mem_out[9]); end
        checks++; if (bad_tag !== 1'b0) begin failures++; $display("FAIL clamp_badtag_cleared got=%b exp=0", bad_tag); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        mem_in = '0;
        for (int k = 0; k < 3; k++) mem_in[k] = num(1'b0, 34'h3_FFFF_FFFF, 7'd0);
        size = 4'd3;
        done_cnt = 0;
        @(negedge clock) eval = 1'b1;
        @(negedge clock) eval = 1'b0;
        repeat (20) @(negedge clock);
        checks++; if (new_size === 6'd0) begin failures++; $display("FAIL restart_midrun got=%0d exp=nonzero", new_size); end
        mem_in = '0;
        mem_in[0] = op(8'h55);
        size = 4'd1;
        run_eval(ok);
        checks++; if (!ok) begin failures++; $display("FAIL restart_timeout got=no_done exp=done"); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL restart_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (new_size !== 6'd1) begin failures++; $display("FAIL restart_newsize got=%0d exp=1", new_size); end
        checks++; if (mem_out[0] !== 8'h55) begin failures++; $display("FAIL restart_tok0 got=%0h exp=55", mem_out[0]); end
    endtask

    task automatic test_const;
        bit ok;
        mem_in = '0;
        mem_in[0] = num(1'b0, 34'd3141592653, -7'sd9);
        mem_in[1] = num(1'b0, 34'd2718281828, -7'sd9);
        size = 4'd2;
`ifdef NUM_TOKENIZER_CONST_EN
        exp_tok = '{8'hC1, 8'hC0};
`else
        exp_tok = '{8'h03, 8'hDD, 8'h01, 8'h04, 8'h01, 8'h05, 8'h09, 8'h02, 8'h06, 8'h05, 8'h03,
                    8'h02, 8'hDD, 8'h07, 8'h01, 8'h08, 8'h02, 8'h08, 8'h01, 8'h08, 8'h02, 8'h08};
`endif
        run_eval(ok);
        checks++; if (!ok) begin failures++; $display("FAIL const_timeout got=no_done exp=done"); end
        checks++; if (new_size !== 6'(exp_tok.size())) begin failures++; $display("FAIL const_newsize got=%0d exp=%0d", new_size, exp_tok.size()); end
        foreach (exp_tok[k]) begin
            checks++;
            if (mem_out[k] !== exp_tok[k]) begin failures++; $display("FAIL const_tok%0d got=%0h exp=%0h", k, mem_out[k], exp_tok[k]); end
        end
    endtask

    task automatic test_reset_mid_div;
        mem_in = '0;
        mem_in[0] = op(8'h77);
        mem_in[1] = num(1'b0, 34'h3_FFFF_FFFF, 7'd0);
        size = 4'd2;
        done_cnt = 0;
        @(negedge clock) eval = 1'b1;
        @(negedge clock) eval = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (new_size !== 6'd0) begin failures++; $display("FAIL rstmid_newsize got=%0d exp=0", new_size); end
        checks++; if (mem_out !== '0) begin failures++; $display("FAIL rstmid_memout got=%0h exp=0", mem_out); end
        checks++; if (overflow !== 1'b0 || bad_tag !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b%b%b exp=000", overflow, bad_tag, done); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt); end
        checks++; if (new_size !== 6'd0) begin failures++; $display("FAIL rstmid_idle_newsize got=%0d exp=0", new_size); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_zero_exp();
        test_overflow();
        test_bad_tag();
        test_size_clamp();
        test_back_to_back();
        test_const();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
